// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache on the fetch path.
// Zero-latency combinational lookup, single-cycle fill, and a one-entry-per-cycle
// fence.i sweep invalidation.
// Optional macro ICACHE_STATS_EN adds lookup_en plus hit/miss counters.
module icache_direct #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] read_addr,
    output logic        read_hit,
    output logic [31:0] read_data,
    output logic        read_is_compressed,
    input  logic        write_en,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        write_is_compressed,
    input  logic        inv_req,
    output logic        inv_busy
`ifdef ICACHE_STATS_EN
    ,
    input  logic        lookup_en,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_WIDTH = 31 - INDEX_WIDTH;
    localparam int ENTRIES   = 1 << INDEX_WIDTH;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_cnt, w_cnt_nxt;

    logic [ENTRIES-1:0]     r_valid;
    logic [TAG_WIDTH-1:0]   r_tag  [ENTRIES];
    logic [31:0]            r_data [ENTRIES];
    logic [ENTRIES-1:0]     r_cmp;

    logic [INDEX_WIDTH-1:0] w_rd_idx, w_wr_idx;
    logic [TAG_WIDTH-1:0]   w_rd_tag, w_wr_tag;
    logic                   w_fill, w_clear;
    logic                   w_unused;

    assign w_rd_idx = read_addr[INDEX_WIDTH:1];
    assign w_rd_tag = read_addr[31:INDEX_WIDTH+1];
    assign w_wr_idx = write_addr[INDEX_WIDTH:1];
    assign w_wr_tag = write_addr[31:INDEX_WIDTH+1];
    // Bit 0 of the PC never selects anything (halfword-aligned fetch).
    assign w_unused = read_addr[0] ^ write_addr[0];

    // An invalidation request in the same cycle wins over a fill.
    assign w_fill   = rdy_in && write_en && (r_state == S_IDLE) && !inv_req;
    assign w_clear  = rdy_in && (r_state == S_SWEEP);
    assign inv_busy = (r_state == S_SWEEP);

    // State and sweep counter registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: start a sweep on request, advance one entry per ready cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (rdy_in && inv_req) begin
                    w_state_nxt = S_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            S_SWEEP: begin
                if (rdy_in) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Valid bits: set on fill, cleared by the sweep; fill and clear never coincide.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= '0;
        end else begin
            if (w_fill) begin
                r_valid[w_wr_idx] <= 1'b1;
            end
            if (w_clear) begin
                r_valid[r_cnt] <= 1'b0;
            end
        end
    end

    // Payload storage (tag, instruction, compressed flag); no reset needed.
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= write_data;
            r_cmp[w_wr_idx]  <= write_is_compressed;
        end
    end

    // Combinational lookup against the current array contents.
    always_comb begin
        read_hit           = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag)
                             && (r_state == S_IDLE);
        read_data          = read_hit ? r_data[w_rd_idx] : '0;
        read_is_compressed = read_hit ? r_cmp[w_rd_idx] : 1'b0;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // Lookup statistics; deliberately untouched by the sweep.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy_in && lookup_en && (r_state == S_IDLE)) begin
            if (read_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule
